// File: rtl/bht_pkg.sv
// Shared types and width helpers for the BHT write-port scheduler.
package bht_pkg;

    localparam int unsigned BHT_ADDR_WIDTH = 32;

    function automatic int unsigned logb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = unsigned'(i) + 32'd1;
        end
        return r;
    endfunction

    function automatic int unsigned h_addr_width(input int unsigned depth);
        return logb2(depth);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned depth);
        return addr_width - logb2(depth) - 2;
    endfunction

    typedef struct packed {
        logic [BHT_ADDR_WIDTH-1:0] pc;
        logic [BHT_ADDR_WIDTH-1:0] target;
        logic                      taken;
        logic                      ret;
    } bht_upd_t;

    typedef enum logic {SWEEP, RUN} bht_state_e;

endpackage

// File: rtl/bht_update_sched_if.sv
// Execute-side update channel and BHT write port of the update scheduler.
interface bht_update_sched_if
    import bht_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned HISTORY_DEPTH = 512
);
    localparam int unsigned H_ADDR_WIDTH = h_addr_width(HISTORY_DEPTH);
    localparam int unsigned TAG_WIDTH    = tag_width(ADDR_WIDTH, HISTORY_DEPTH);

    logic                    EX_VALID;
    logic                    EX_READY;
    logic [ADDR_WIDTH-1:0]   EX_PC;
    logic [ADDR_WIDTH-1:0]   EX_TARGET;
    logic                    EX_TAKEN;
    logic                    EX_PREDICTED;
    logic                    EX_RETURN;

    logic                    WR_EN;
    logic                    WR_READY;
    logic                    WR_CLEAR;
    logic [H_ADDR_WIDTH-1:0] WR_IDX;
    logic [TAG_WIDTH-1:0]    WR_TAG;
    logic [ADDR_WIDTH-1:0]   WR_TARGET;
    logic                    WR_TAKEN;
    logic                    WR_RETURN;

    // master is the scheduler: it drives the BHT write port and accepts updates
    modport master (
        input  EX_VALID, EX_PC, EX_TARGET, EX_TAKEN, EX_PREDICTED, EX_RETURN, WR_READY,
        output EX_READY, WR_EN, WR_CLEAR, WR_IDX, WR_TAG, WR_TARGET, WR_TAKEN, WR_RETURN
    );

    modport slave (
        output EX_VALID, EX_PC, EX_TARGET, EX_TAKEN, EX_PREDICTED, EX_RETURN, WR_READY,
        input  EX_READY, WR_EN, WR_CLEAR, WR_IDX, WR_TAG, WR_TARGET, WR_TAKEN, WR_RETURN
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO for pending BHT updates; wrap-bit pointers, flush discards all contents.
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = bht_upd_t
) (
    input  logic CLK,
    input  logic RST,
    input  logic flush,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int unsigned AW = logb2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    T            mem_q [DEPTH];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) wptr_q <= wptr_q + 1'b1;
            if (pop && !empty) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bht_update_sched.sv
// BHT write-port scheduler: invalidation sweep after reset/INV_REQ, then drains queued updates.
// Optional statistics counters built only when BHT_PERF_CNT_EN is defined.
module bht_update_sched
    import bht_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned HISTORY_DEPTH = 512,
    parameter int unsigned QUEUE_DEPTH   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    bht_update_sched_if.master        bus,
    input  logic                      INV_REQ,
    output logic                      INV_BUSY,
    output logic                      INV_DONE,
    output logic [31:0]               BR_COUNT,
    output logic [31:0]               MISPRED_COUNT
);
    localparam int unsigned H_ADDR_WIDTH = h_addr_width(HISTORY_DEPTH);

    bht_state_e              state_q;
    logic [H_ADDR_WIDTH-1:0] sweep_idx_q;
    logic                    q_full, q_empty, enq, deq, flush, sweep_last;
    bht_upd_t                enq_entry, head;

    assign enq        = bus.EX_VALID && !q_full;
    assign deq        = (state_q == RUN) && !q_empty && bus.WR_READY;
    // An entry enqueued alongside INV_REQ is dropped too: flush beats push in the FIFO
    assign flush      = (state_q == RUN) && INV_REQ;
    assign sweep_last = (state_q == SWEEP) && bus.WR_READY &&
                        (sweep_idx_q == H_ADDR_WIDTH'(HISTORY_DEPTH - 1));

    assign bus.EX_READY = !q_full;
    assign INV_BUSY     = (state_q == SWEEP);
    assign INV_DONE     = sweep_last;

    assign enq_entry = '{pc:     BHT_ADDR_WIDTH'(bus.EX_PC),
                         target: BHT_ADDR_WIDTH'(bus.EX_TARGET),
                         taken:  bus.EX_TAKEN,
                         ret:    bus.EX_RETURN};

    bht_upd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (bht_upd_t)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .push  (enq),
        .wdata (enq_entry),
        .pop   (deq),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
        end else begin
            unique case (state_q)
                SWEEP: begin
                    // Index wraps to 0 naturally on the final write
                    if (bus.WR_READY) sweep_idx_q <= sweep_idx_q + 1'b1;
                    if (sweep_last)   state_q     <= RUN;
                end
                RUN: begin
                    if (INV_REQ) begin
                        state_q     <= SWEEP;
                        sweep_idx_q <= '0;
                    end
                end
                default: state_q <= SWEEP;
            endcase
        end
    end

    always_comb begin
        bus.WR_EN     = 1'b0;
        bus.WR_CLEAR  = 1'b0;
        bus.WR_IDX    = '0;
        bus.WR_TAG    = '0;
        bus.WR_TARGET = '0;
        bus.WR_TAKEN  = 1'b0;
        bus.WR_RETURN = 1'b0;
        if (state_q == SWEEP) begin
            bus.WR_EN    = 1'b1;
            bus.WR_CLEAR = 1'b1;
            bus.WR_IDX   = sweep_idx_q;
        end else begin
            bus.WR_EN     = !q_empty;
            bus.WR_IDX    = head.pc[H_ADDR_WIDTH+1:2];
            bus.WR_TAG    = head.pc[ADDR_WIDTH-1:H_ADDR_WIDTH+2];
            bus.WR_TARGET = head.target[ADDR_WIDTH-1:0];
            bus.WR_TAKEN  = head.taken;
            bus.WR_RETURN = head.ret;
        end
    end

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^head.pc[1:0];

`ifdef BHT_PERF_CNT_EN
    logic [31:0] br_count_q, mispred_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (enq) begin
            br_count_q <= br_count_q + 32'd1;
            if (bus.EX_TAKEN != bus.EX_PREDICTED) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign BR_COUNT      = br_count_q;
    assign MISPRED_COUNT = mispred_count_q;
`else
    logic unused_predicted;
    assign unused_predicted = bus.EX_PREDICTED;
    assign BR_COUNT         = '0;
    assign MISPRED_COUNT    = '0;
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Randomized bench for bht_update_sched against a queue-based behavioural model.
module tb_bht_update_sched;
    import bht_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned HD  = 512;
    localparam int unsigned QD  = 4;
    localparam int unsigned HAW = 9;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INV_REQ;
    logic        INV_BUSY, INV_DONE;
    logic [31:0] BR_COUNT, MISPRED_COUNT;

    always #5 CLK = ~CLK;

    bht_update_sched_if #(.ADDR_WIDTH(AW), .HISTORY_DEPTH(HD)) bus ();

    bht_update_sched #(
        .ADDR_WIDTH    (AW),
        .HISTORY_DEPTH (HD),
        .QUEUE_DEPTH   (QD)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .bus           (bus),
        .INV_REQ       (INV_REQ),
        .INV_BUSY      (INV_BUSY),
        .INV_DONE      (INV_DONE),
        .BR_COUNT      (BR_COUNT),
        .MISPRED_COUNT (MISPRED_COUNT)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        bit          taken;
        bit          ret;
    } upd_t;

    upd_t        mq[$];
    bit          m_sweep;
    int unsigned m_idx;
    int unsigned m_br, m_mis;
    int          n_pass = 0, n_total = 0;
    int          busy_cnt, done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic compare();
        logic [63:0] e_idx, e_tag, e_tgt, e_br, e_mis;
        bit          e_en, e_clr, e_tkn, e_ret;
        e_en = m_sweep || (mq.size() > 0);
        e_clr = m_sweep;
        e_idx = 0; e_tag = 0; e_tgt = 0; e_tkn = 0; e_ret = 0;
        if (m_sweep) begin
            e_idx = 64'(m_idx);
        end else if (mq.size() > 0) begin
            e_idx = 64'((mq[0].pc >> 2) % HD);
            e_tag = 64'(mq[0].pc >> (HAW + 2));
            e_tgt = 64'(mq[0].target);
            e_tkn = mq[0].taken;
            e_ret = mq[0].ret;
        end
`ifdef BHT_PERF_CNT_EN
        e_br  = 64'(m_br);
        e_mis = 64'(m_mis);
`else
        e_br  = 0;
        e_mis = 0;
`endif
        check("ex_ready", 64'(bus.EX_READY), 64'(mq.size() < QD));
        check("inv_busy", 64'(INV_BUSY), 64'(m_sweep));
        check("inv_done", 64'(INV_DONE), 64'(m_sweep && bus.WR_READY && m_idx == HD - 1));
        check("wr_en", 64'(bus.WR_EN), 64'(e_en));
        if (e_en) begin
            check("wr_clear", 64'(bus.WR_CLEAR), 64'(e_clr));
            check("wr_idx", 64'(bus.WR_IDX), e_idx);
            check("wr_tag", 64'(bus.WR_TAG), e_tag);
            check("wr_target", 64'(bus.WR_TARGET), e_tgt);
            check("wr_taken", 64'(bus.WR_TAKEN), 64'(e_tkn));
            check("wr_return", 64'(bus.WR_RETURN), 64'(e_ret));
        end
        check("br_count", 64'(BR_COUNT), e_br);
        check("mispred_count", 64'(MISPRED_COUNT), e_mis);
    endtask

    // Sample at negedge, then advance the model on the posedge with the same inputs
    task automatic cycle();
        bit   acc;
        upd_t u;
        @(negedge CLK);
        if (!RST) begin
            compare();
            if (INV_BUSY) busy_cnt++;
            if (INV_DONE) done_cnt++;
        end
        @(posedge CLK);
        if (RST) begin
            m_sweep = 1; m_idx = 0; mq.delete(); m_br = 0; m_mis = 0;
        end else begin
            acc = bus.EX_VALID && (mq.size() < QD);
            u = '{pc: bus.EX_PC, target: bus.EX_TARGET, taken: bus.EX_TAKEN, ret: bus.EX_RETURN};
            if (acc) begin
                m_br++;
                if (bus.EX_TAKEN != bus.EX_PREDICTED) m_mis++;
            end
            if (m_sweep) begin
                if (bus.WR_READY) begin
                    if (m_idx == HD - 1) begin
                        m_sweep = 0;
                        m_idx   = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (INV_REQ) begin
                mq.delete();
                m_sweep = 1;
                m_idx   = 0;
                acc     = 0;
            end else if (bus.WR_READY && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(u);
        end
        #1;
    endtask

    task automatic idle();
        bus.EX_VALID = 0;
        INV_REQ      = 0;
    endtask

    task automatic rand_upd();
        bus.EX_PC        = $urandom;
        bus.EX_TARGET    = $urandom;
        bus.EX_TAKEN     = 1'($urandom);
        bus.EX_PREDICTED = 1'($urandom);
        bus.EX_RETURN    = 1'($urandom);
    endtask

    initial begin
        RST = 1;
        idle();
        rand_upd();
        bus.WR_READY = 1;
        repeat (2) cycle();
        RST = 0;

        // Reset state, then a full sweep at WR_READY=1
        check("rst_wr_en", 64'(bus.WR_EN), 64'd1);
        check("rst_wr_idx", 64'(bus.WR_IDX), 64'd0);
        check("rst_ex_ready", 64'(bus.EX_READY), 64'd1);
        busy_cnt = 0; done_cnt = 0;
        repeat (HD) cycle();
        check("sweep_len", 64'(busy_cnt), 64'(HD));
        check("sweep_done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after_sweep", 64'(INV_BUSY), 64'd0);

        // Directed update, visible one cycle after enqueue
        bus.EX_PC = 32'h0000_1008; bus.EX_TARGET = 32'h2000;
        bus.EX_TAKEN = 1; bus.EX_PREDICTED = 0; bus.EX_RETURN = 0;
        bus.EX_VALID = 1;
        cycle();
        idle();
        check("dir_wr_en", 64'(bus.WR_EN), 64'd1);
        check("dir_wr_idx", 64'(bus.WR_IDX), 64'd2);
        check("dir_wr_taken", 64'(bus.WR_TAKEN), 64'd1);
        cycle();

        // Back-pressure: 5 offers into a 4-deep queue, then drain
        bus.WR_READY = 0;
        for (int i = 0; i < 5; i++) begin
            rand_upd();
            bus.EX_VALID = 1;
            cycle();
        end
        check("full_ex_ready", 64'(bus.EX_READY), 64'd0);
        idle();
        repeat (3) cycle();
        bus.WR_READY = 1;
        repeat (4) cycle();
        check("drained", 64'(bus.WR_EN), 64'd0);

        // Flush: 3 queued, INV_REQ with a concurrent 4th offer
        bus.WR_READY = 0;
        for (int i = 0; i < 3; i++) begin
            rand_upd();
            bus.EX_VALID = 1;
            cycle();
        end
        rand_upd();
        bus.EX_VALID = 1;
        INV_REQ = 1;
        cycle();
        idle();
        bus.WR_READY = 1;
        busy_cnt = 0; done_cnt = 0;
        repeat (HD) cycle();
        check("flush_sweep_len", 64'(busy_cnt), 64'(HD));
        check("flush_no_write", 64'(bus.WR_EN), 64'd0);

        // Updates and an ignored INV_REQ during a sweep
        INV_REQ = 1;
        busy_cnt = 0; done_cnt = 0;
        cycle();
        idle();
        for (int i = 0; i < HD; i++) begin
            idle();
            if (i == 10 || i == 20) begin
                rand_upd();
                bus.EX_VALID = 1;
            end
            if (i == 200) INV_REQ = 1;
            cycle();
        end
        idle();
        check("mid_sweep_len", 64'(busy_cnt), 64'(HD));
        check("post_sweep_wr_en", 64'(bus.WR_EN), 64'd1);
        repeat (3) cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_upd();
            bus.EX_VALID = 1'($urandom_range(0, 1));
            bus.WR_READY = ($urandom_range(0, 9) < 7);
            INV_REQ      = ($urandom_range(0, 399) == 0);
            cycle();
        end

        // Reset with a non-empty queue restarts the sweep
        idle();
        bus.WR_READY = 0;
        repeat (2) begin
            rand_upd();
            bus.EX_VALID = 1;
            cycle();
        end
        RST = 1;
        cycle();
        RST = 0;
        idle();
        bus.WR_READY = 1;
        check("rerst_wr_idx", 64'(bus.WR_IDX), 64'd0);
        check("rerst_busy", 64'(INV_BUSY), 64'd1);
        repeat (HD + 5) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
